// File: rtl/multicycle_control_if.sv
// multicycle_control_if: opcode/flag inputs and decoded control outputs of the multicycle controller
interface multicycle_control_if #(parameter int CNT_W = 32);
    logic [6:0]       op;
    logic             zero;
    logic             mem_ready;
    logic             PCWrite;
    logic             AdrSrc;
    logic             MemWrite;
    logic             IRWrite;
    logic             RegWrite;
    logic [1:0]       ResultSrc;
    logic [1:0]       ALUSrcA;
    logic [1:0]       ALUSrcB;
    logic [1:0]       ALUOp;
    logic [1:0]       ImmSrc;
    logic             illegal;
    logic [3:0]       state_o;
    logic [CNT_W-1:0] instret;
    modport master (
        output op, zero, mem_ready,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ALUOp, ImmSrc, illegal, state_o, instret
    );
    modport slave (
        input  op, zero, mem_ready,
        output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ALUOp, ImmSrc, illegal, state_o, instret
    );
endinterface

// File: rtl/multicycle_control.sv
// multicycle_control: RISC-V multicycle main FSM with Moore control decode and retired-instruction counter
module multicycle_control #(
    parameter bit SUPPORT_JAL = 1'b1,
    parameter int CNT_W       = 32
) (
    input logic                clk,
    input logic                rst,
    multicycle_control_if.slave bus
);
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_ILLEGAL  = 4'd11
    } state_t;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             retire;
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    state_d = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE:
                case (bus.op)
                    7'b0000011, 7'b0100011: state_d = S_MEMADR;
                    7'b0110011:             state_d = S_EXECUTER;
                    7'b0010011:             state_d = S_EXECUTEI;
                    7'b1100011:             state_d = S_BEQ;
                    7'b1101111:             state_d = SUPPORT_JAL ? S_JAL : S_ILLEGAL;
                    default:                state_d = S_ILLEGAL;
                endcase
            S_MEMADR:   state_d = (bus.op == 7'b0000011) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = bus.mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWRITE: state_d = bus.mem_ready ? S_FETCH : S_MEMWRITE;
            S_MEMWB, S_ALUWB, S_BEQ:             state_d = S_FETCH;
            S_EXECUTER, S_EXECUTEI, S_JAL:       state_d = S_ALUWB;
            default:    state_d = state_q;
        endcase
    end
    // An instruction retires on the edge that leaves its final state for FETCH.
    assign retire    = (state_d == S_FETCH) &&
                       (state_q inside {S_MEMWB, S_MEMWRITE, S_ALUWB, S_BEQ});
    assign instret_d = instret_q + {{(CNT_W-1){1'b0}}, retire};
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end
    always_comb begin
        bus.PCWrite   = 1'b0;
        bus.AdrSrc    = 1'b0;
        bus.MemWrite  = 1'b0;
        bus.IRWrite   = 1'b0;
        bus.RegWrite  = 1'b0;
        bus.ResultSrc = 2'b00;
        bus.ALUSrcA   = 2'b00;
        bus.ALUSrcB   = 2'b00;
        bus.ALUOp     = 2'b00;
        case (state_q)
            S_FETCH: begin
                bus.ResultSrc = 2'b10;
                bus.ALUSrcB   = 2'b10;
                bus.IRWrite   = bus.mem_ready;
                bus.PCWrite   = bus.mem_ready;
            end
            S_DECODE: begin
                bus.ALUSrcA = 2'b01;
                bus.ALUSrcB = 2'b01;
            end
            S_MEMADR, S_EXECUTEI: begin
                bus.ALUSrcA = 2'b10;
                bus.ALUSrcB = 2'b01;
                bus.ALUOp   = (state_q == S_EXECUTEI) ? 2'b10 : 2'b00;
            end
            S_MEMREAD:  bus.AdrSrc = 1'b1;
            S_MEMWB: begin
                bus.ResultSrc = 2'b01;
                bus.RegWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                bus.AdrSrc   = 1'b1;
                bus.MemWrite = 1'b1;
            end
            S_EXECUTER: begin
                bus.ALUSrcA = 2'b10;
                bus.ALUOp   = 2'b10;
            end
            S_ALUWB:    bus.RegWrite = 1'b1;
            S_BEQ: begin
                bus.ALUSrcA = 2'b10;
                bus.ALUOp   = 2'b01;
                bus.PCWrite = bus.zero;
            end
            S_JAL: begin
                bus.ALUSrcA = 2'b01;
                bus.ALUSrcB = 2'b10;
                bus.PCWrite = 1'b1;
            end
            default: ;
        endcase
    end
    assign bus.ImmSrc  = (bus.op == 7'b0100011) ? 2'b01 :
                         (bus.op == 7'b1100011) ? 2'b10 :
                         (SUPPORT_JAL && bus.op == 7'b1101111) ? 2'b11 : 2'b00;
    assign bus.illegal = (state_q == S_ILLEGAL);
    assign bus.state_o = state_q;
    assign bus.instret = instret_q;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: vector table with scoreboard queue plus directed JAL-disable and counter-wrap sequences
module tb_multicycle_control;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    typedef struct {
        logic        rst;
        logic [6:0]  op;
        logic        zero;
        logic        mr;
        logic [3:0]  st;
        logic [31:0] ir;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] op;
    logic       zero;
    logic       mr;
    int         errors = 0;
    int         checks = 0;
    vec_t       tbl[$];
    vec_t       exp_q[$];
    logic [13:0] base[12];

    multicycle_control_if #(.CNT_W(32)) bus_m();
    multicycle_control_if #(.CNT_W(32)) bus_n();
    multicycle_control_if #(.CNT_W(4))  bus_s();

    assign bus_m.op = op;  assign bus_m.zero = zero;  assign bus_m.mem_ready = mr;
    assign bus_n.op = op;  assign bus_n.zero = zero;  assign bus_n.mem_ready = mr;
    assign bus_s.op = op;  assign bus_s.zero = zero;  assign bus_s.mem_ready = mr;

    multicycle_control #(.SUPPORT_JAL(1'b1), .CNT_W(32)) dut_m (.clk(clk), .rst(rst), .bus(bus_m));
    multicycle_control #(.SUPPORT_JAL(1'b0), .CNT_W(32)) dut_n (.clk(clk), .rst(rst), .bus(bus_n));
    multicycle_control #(.SUPPORT_JAL(1'b1), .CNT_W(4))  dut_s (.clk(clk), .rst(rst), .bus(bus_s));

    always #5 clk = ~clk;

    logic [13:0] act_ctl;
    assign act_ctl = {bus_m.PCWrite, bus_m.AdrSrc, bus_m.MemWrite, bus_m.IRWrite, bus_m.RegWrite,
                      bus_m.ResultSrc, bus_m.ALUSrcA, bus_m.ALUSrcB, bus_m.ALUOp, bus_m.illegal};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [6:0] o, input logic z, input logic m,
                       input logic [3:0] s, input logic [31:0] i);
        vec_t v;
        v.rst = r; v.op = o; v.zero = z; v.mr = m; v.st = s; v.ir = i;
        tbl.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] exp_imm(input logic [6:0] o);
        return (o == OP_SW) ? 2'b01 : (o == OP_BEQ) ? 2'b10 : (o == OP_JAL) ? 2'b11 : 2'b00;
    endfunction

    initial begin
        // {PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUOp,illegal}
        base = '{14'b00000_10_00_10_00_0, 14'b00000_00_01_01_00_0, 14'b00000_00_10_01_00_0,
                 14'b01000_00_00_00_00_0, 14'b00001_01_00_00_00_0, 14'b01100_00_00_00_00_0,
                 14'b00000_00_10_00_10_0, 14'b00000_00_10_01_10_0, 14'b00001_00_00_00_00_0,
                 14'b00000_00_10_00_01_0, 14'b10000_00_01_10_00_0, 14'b00000_00_00_00_00_1};
        add(0, OP_R, 0, 1, 0, 0); add(0, OP_R, 0, 1, 1, 0); add(0, OP_R, 0, 1, 6, 0); add(0, OP_R, 0, 1, 8, 0);
        add(0, OP_I, 0, 1, 0, 1); add(0, OP_I, 0, 1, 1, 1); add(0, OP_I, 0, 1, 7, 1); add(0, OP_I, 0, 1, 8, 1);
        add(0, OP_LW, 0, 1, 0, 2); add(0, OP_LW, 0, 1, 1, 2); add(0, OP_LW, 0, 1, 2, 2);
        add(0, OP_LW, 0, 0, 3, 2); add(0, OP_LW, 0, 0, 3, 2); add(0, OP_LW, 0, 0, 3, 2);
        add(0, OP_LW, 0, 1, 3, 2); add(0, OP_LW, 0, 1, 4, 2);
        add(0, OP_SW, 0, 0, 0, 3); add(0, OP_SW, 0, 1, 0, 3); add(0, OP_SW, 0, 1, 1, 3);
        add(0, OP_SW, 0, 1, 2, 3); add(0, OP_SW, 0, 0, 5, 3); add(0, OP_SW, 0, 1, 5, 3);
        add(0, OP_BEQ, 0, 1, 0, 4); add(0, OP_BEQ, 0, 1, 1, 4); add(0, OP_BEQ, 0, 1, 9, 4);
        add(0, OP_BEQ, 1, 1, 0, 5); add(0, OP_BEQ, 1, 1, 1, 5); add(0, OP_BEQ, 1, 1, 9, 5);
        add(0, OP_JAL, 0, 1, 0, 6); add(0, OP_JAL, 0, 1, 1, 6); add(0, OP_JAL, 0, 1, 10, 6); add(0, OP_JAL, 0, 1, 8, 6);
        add(0, OP_BAD, 0, 1, 0, 7); add(0, OP_BAD, 0, 1, 1, 7);
        for (int k = 0; k < 10; k++) add(0, OP_BAD, 0, 1, 11, 7);
        add(1, OP_BAD, 0, 1, 11, 7);
        add(0, OP_SW, 0, 1, 0, 0); add(0, OP_SW, 0, 1, 1, 0); add(0, OP_SW, 0, 1, 2, 0);
        add(0, OP_SW, 0, 0, 5, 0); add(1, OP_SW, 0, 0, 5, 0); add(0, OP_SW, 0, 0, 0, 0);

        rst = 1'b1; op = OP_R; zero = 1'b0; mr = 1'b1;
        tick(); tick();
        foreach (tbl[i]) begin
            vec_t e;
            logic [13:0] ec;
            rst = tbl[i].rst; op = tbl[i].op; zero = tbl[i].zero; mr = tbl[i].mr;
            exp_q.push_back(tbl[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            ec = base[e.st];
            if (e.st == 4'd0) begin ec[13] = e.mr; ec[10] = e.mr; end
            if (e.st == 4'd9) ec[13] = e.zero;
            chk($sformatf("row%0d state", i), 32'(bus_m.state_o), 32'(e.st));
            chk($sformatf("row%0d ctl", i), 32'(act_ctl), 32'(ec));
            chk($sformatf("row%0d imm", i), 32'(bus_m.ImmSrc), 32'(exp_imm(e.op)));
            chk($sformatf("row%0d instret", i), bus_m.instret, e.ir);
            tick();
        end

        // JAL with decode disabled must trap while the enabled instance executes it.
        rst = 1'b1; op = OP_JAL; mr = 1'b1; zero = 1'b0;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("jal fetch m", 32'(bus_m.state_o), 0);
        chk("jal fetch n", 32'(bus_n.state_o), 0);
        tick(); tick();
        @(negedge clk);
        chk("jal state m", 32'(bus_m.state_o), 10);
        chk("jal pcwrite m", 32'(bus_m.PCWrite), 1);
        chk("jal imm m", 32'(bus_m.ImmSrc), 3);
        chk("nojal state", 32'(bus_n.state_o), 11);
        chk("nojal illegal", 32'(bus_n.illegal), 1);
        chk("nojal pcwrite", 32'(bus_n.PCWrite), 0);
        chk("nojal imm", 32'(bus_n.ImmSrc), 0);
        tick();
        @(negedge clk);
        chk("jal aluwb m", 32'(bus_m.state_o), 8);
        tick();
        @(negedge clk);
        chk("jal done m", 32'(bus_m.state_o), 0);
        chk("jal instret m", bus_m.instret, 1);
        chk("nojal stuck", 32'(bus_n.state_o), 11);

        // Narrow counter wraps after 16 back-to-back R-type instructions.
        rst = 1'b1; op = OP_R;
        tick();
        rst = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            repeat (4) tick();
            @(negedge clk);
            if (k == 15) chk("wrap pre", 32'(bus_s.instret), 15);
        end
        chk("wrap post", 32'(bus_s.instret), 0);
        chk("wide no wrap", bus_m.instret, 16);
        chk("wrap state", 32'(bus_s.state_o), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
